cell_stim_misr: RTL
===================

CELL_STIM_MISR -- requirements
Module: cell_stim_misr

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning stimulus width (legal 1..8).
REQ-002 The block SHALL have parameter N_OUT, default 2, meaning response width (legal 1..16).
REQ-003 The block SHALL have parameter SETTLE, default 3, meaning settle cycles per vector (legal 1..15).
REQ-004 The block SHALL have port CLK, input, 1 bit: single clock, all state rising-edge.
REQ-005 The block SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port START, input, 1 bit: begin a run.
REQ-007 The block SHALL have port ABORT, input, 1 bit: terminate a run.
REQ-008 The block SHALL have port MODE, input, 1 bit: 0 = exhaustive count, 1 = walking-ones; sampled at START accept.
REQ-009 The block SHALL have port STIM, output, N_IN bits: drives the inputs of the cell under test.
REQ-010 The block SHALL have port RESP, input, N_OUT bits: cell-under-test outputs.
REQ-011 The block SHALL have port BUSY, output, 1 bit: run in progress.
REQ-012 The block SHALL have port DONE, output, 1 bit: run complete, signature valid.
REQ-013 The block SHALL have port SIG, output, 16 bits: MISR signature.
REQ-014 The block SHALL have port VEC_CNT, output, N_IN+1 bits: vectors captured in the current or last run.

Function
REQ-015 The FSM SHALL have states IDLE, SETTLE, CAPTURE and DONE.
REQ-016 START in IDLE or DONE SHALL load STIM with the first vector (mode 0: 0; mode 1: 1), set SIG to 16'h0001, clear VEC_CNT, load the settle counter with SETTLE-1, clear DONE and enter SETTLE.
REQ-017 START in SETTLE or CAPTURE SHALL be ignored.
REQ-018 SETTLE SHALL decrement the counter each cycle and enter CAPTURE in the cycle after the counter reaches 0, so STIM is held stable for exactly SETTLE cycles before capture.
REQ-019 CAPTURE SHALL update SIG as next = {SIG[14:0], fb} XOR zero-extended RESP, with fb = SIG[15]^SIG[13]^SIG[12]^SIG[10], and SHALL increment VEC_CNT.
REQ-020 In CAPTURE, a non-last vector SHALL advance STIM (mode 0: +1; mode 1: shift left 1), reload the counter and return to SETTLE.
REQ-021 The last vector SHALL be 2^N_IN-1 in mode 0 and 1<<(N_IN-1) in mode 1; after capturing it the block SHALL enter DONE.
REQ-022 Per-vector cost SHALL be SETTLE+1 cycles; DONE SHALL assert V*(SETTLE+1) cycles after the START-accept edge, where V = 2^N_IN (mode 0) or N_IN (mode 1).
REQ-023 BUSY SHALL be high in SETTLE and CAPTURE only.
REQ-024 DONE SHALL be high only in DONE and SHALL hold until START or ABORT.
REQ-025 ABORT in any state SHALL go to IDLE next cycle with STIM=0 and DONE=0, retaining SIG and VEC_CNT.
REQ-026 When ABORT and START are asserted together, ABORT SHALL win.
REQ-027 In IDLE and DONE, STIM SHALL hold its last value except as required by REQ-025.
REQ-028 For N_OUT<16, RESP SHALL be zero-extended; VEC_CNT SHALL not wrap because its N_IN+1 bits hold 2^N_IN.

Reset
REQ-029 While RESET_N is low, the FSM SHALL be in IDLE, with STIM=0, BUSY=0, DONE=0, SIG=16'h0001, VEC_CNT=0 and the counter at 0, independent of CLK.
REQ-030 Reset deassertion mid-run SHALL resume from IDLE; no partial run continues.

Structure
REQ-031 Package cell_test_pkg SHALL hold the state enum, MISR_W=16, MISR_SEED=16'h0001 and the tap mask.
REQ-032 The MISR SHALL be sub-module cell_test_misr, with inputs clk, reset, load-seed, enable and data, and the signature as output.
REQ-033 Parameter legality SHALL be checked at elaboration.

Verification
REQ-034 Test: N_IN=2, SETTLE=3, mode 0, RESP tied 0, START pulse -> STIM 0,1,2,3 each held 4 cycles; DONE at cycle 16; VEC_CNT=4; SIG=16'h0010.
REQ-035 Test: N_IN=4, mode 1, SETTLE=1 -> STIM 1,2,4,8 each held 2 cycles; DONE at cycle 8; VEC_CNT=4.
REQ-036 Test: N_IN=1, N_OUT=1, SETTLE=1, RESP=STIM -> capture 1 gives 0x0002, capture 2 gives 0x0005; final SIG=16'h0005.
REQ-037 Test: ABORT and START together at cycle 5 of a run -> IDLE next cycle, STIM=0, BUSY=0, DONE=0, SIG and VEC_CNT unchanged.
REQ-038 Test: RESET_N low asynchronously mid-SETTLE -> all outputs at reset values before the next CLK edge; START after release runs a full run.
REQ-039 Test: START repeated while BUSY is high -> ignored and run length unchanged; START in DONE -> restarts with SIG reseeded.

Source files
------------

// File: rtl/cell_test_pkg.sv
// Shared types and MISR constants for the cell stimulus/signature tester.
`default_nettype none
package cell_test_pkg;

    localparam int MISR_W = 16;
    localparam logic [MISR_W-1:0] MISR_SEED = 16'h0001;
    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [MISR_W-1:0] MISR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] cur,
                                                     input logic [MISR_W-1:0] data);
        return {cur[MISR_W-2:0], ^(cur & MISR_TAPS)} ^ data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cell_test_misr.sv
// 16-bit multiple-input signature register; seed load has priority over compaction.
`default_nettype none
module cell_test_misr
    import cell_test_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_seed,
    input  logic              enable,
    input  logic [MISR_W-1:0] data,
    output logic [MISR_W-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= MISR_SEED;
        end else if (load_seed) begin
            sig <= MISR_SEED;
        end else if (enable) begin
            sig <= misr_next(sig, data);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cell_stim_misr.sv
// Applies exhaustive or walking-ones vectors to a cell under test and compacts its responses.
`default_nettype none
module cell_stim_misr
    import cell_test_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic              mode,
    output logic [N_IN-1:0]   stim,
    input  logic [N_OUT-1:0]  resp,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] sig,
    output logic [N_IN:0]     vec_cnt
);

    if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
        $error("cell_stim_misr: N_IN must be in 1..8");
    end
    if (N_OUT < 1 || N_OUT > 16) begin : g_bad_n_out
        $error("cell_stim_misr: N_OUT must be in 1..16");
    end
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
        $error("cell_stim_misr: SETTLE must be in 1..15");
    end

    localparam logic [3:0]      SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
    localparam logic [N_IN:0]   CNT_ONE   = (N_IN + 1)'(1);

    state_t              state;
    logic [3:0]          cnt;
    logic                walk;
    logic                accept;
    logic                capture;
    logic                last_vec;
    logic [MISR_W-1:0]   resp_ext;

    assign accept   = start && !abort && (state == ST_IDLE || state == ST_DONE);
    assign capture  = (state == ST_CAPTURE) && !abort;
    assign last_vec = walk ? stim[N_IN-1] : (&stim);

    always_comb begin
        resp_ext             = '0;
        resp_ext[N_OUT-1:0]  = resp;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            stim    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            walk    <= 1'b0;
            vec_cnt <= '0;
        end else if (abort) begin
            // Signature and vector count are kept for post-mortem inspection.
            state <= ST_IDLE;
            stim  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state   <= ST_SETTLE;
                        stim    <= mode ? VEC_ONE : '0;
                        walk    <= mode;
                        cnt     <= SETTLE_M1;
                        vec_cnt <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == 4'd0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    vec_cnt <= vec_cnt + CNT_ONE;
                    if (last_vec) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        stim  <= walk ? (stim << 1) : (stim + VEC_ONE);
                        cnt   <= SETTLE_M1;
                        state <= ST_SETTLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    cell_test_misr u_misr (
        .clk       (clk),
        .rst_n     (reset_n),
        .load_seed (accept),
        .enable    (capture),
        .data      (resp_ext),
        .sig       (sig)
    );

endmodule
`default_nettype wire
